// File: rtl/calc2_port_driver_if.sv
// Request, calc2 port and completion bundle for one calc2_port_driver.
// master is the driver's view; slave is the side that feeds requests and models calc2.
interface calc2_port_driver_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [3:0]  calc_cmd_out;
  logic [31:0] calc_data_out;
  logic [1:0]  calc_tag_out;
  logic [1:0]  calc_resp_in;
  logic [31:0] calc_data_in;
  logic [1:0]  calc_tag_in;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_tag;

  modport master (
    input  req_valid, req_cmd, req_op1, req_op2,
    input  calc_resp_in, calc_data_in, calc_tag_in,
    output req_ready,
    output calc_cmd_out, calc_data_out, calc_tag_out,
    output rsp_valid, rsp_status, rsp_data, rsp_tag
  );

  modport slave (
    output req_valid, req_cmd, req_op1, req_op2,
    output calc_resp_in, calc_data_in, calc_tag_in,
    input  req_ready,
    input  calc_cmd_out, calc_data_out, calc_tag_out,
    input  rsp_valid, rsp_status, rsp_data, rsp_tag
  );
endinterface

// File: rtl/calc2_port_driver.sv
// Tags whole ops, issues them over two calc2 port cycles and returns one completion per op.
// Issue starts the cycle after accept; req_ready drops while in ISSUE1 or with all 4 tags in use.
module calc2_port_driver #(
  parameter int TIMEOUT = 16
) (
  input  logic                 c_clk,
  input  logic                 reset,
  calc2_port_driver_if.master  bus,
  output logic                 busy,
  output logic                 spurious_err
);

  typedef enum logic [1:0] {IDLE, ISSUE1, ISSUE2} state_e;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_e      state_q;
  logic [1:0]  tag_q;
  logic [31:0] op2_q;
  logic [3:0]  out_q;
  logic [7:0]  cnt_q [4];
  logic [3:0]  calc_cmd_q;
  logic [31:0] calc_data_q;
  logic [1:0]  calc_tag_q;
  logic        rsp_valid_q;
  logic [1:0]  rsp_status_q;
  logic [31:0] rsp_data_q;
  logic [1:0]  rsp_tag_q;
  logic        spurious_q;

  logic [3:0]  used;
  logic [3:0]  pending;
  logic [1:0]  free_tag;
  logic [1:0]  pend_tag;
  logic        free_any;
  logic        pend_any;
  logic        req_ready;
  logic        accept;
  logic        resp_hit;
  logic        resp_spur;
  logic        fire_to;

  // The tag being issued is reserved but not yet outstanding, so it cannot be reallocated.
  always_comb begin
    used     = out_q;
    if (state_q != IDLE) used[tag_q] = 1'b1;
    free_any = ~&used;
    free_tag = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!used[i]) free_tag = 2'(i);
    end
    pend_any = 1'b0;
    pend_tag = 2'd0;
    for (int i = 0; i < 4; i++) begin
      pending[i] = out_q[i] && (cnt_q[i] == TO);
    end
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) begin
        pend_any = 1'b1;
        pend_tag = 2'(i);
      end
    end
  end

  assign req_ready = !reset && (state_q == IDLE || state_q == ISSUE2) && free_any;
  assign accept    = bus.req_valid && req_ready;
  assign resp_hit  = (bus.calc_resp_in != 2'd0) && out_q[bus.calc_tag_in];
  assign resp_spur = (bus.calc_resp_in != 2'd0) && !out_q[bus.calc_tag_in];
  assign fire_to   = !resp_hit && pend_any;

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tag_q        <= 2'd0;
      op2_q        <= 32'd0;
      out_q        <= 4'd0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
      calc_cmd_q   <= 4'd0;
      calc_data_q  <= 32'd0;
      calc_tag_q   <= 2'd0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 2'd0;
      rsp_data_q   <= 32'd0;
      rsp_tag_q    <= 2'd0;
      spurious_q   <= 1'b0;
    end else begin
      if (accept) begin
        state_q     <= ISSUE1;
        tag_q       <= free_tag;
        op2_q       <= bus.req_op2;
        calc_cmd_q  <= bus.req_cmd;
        calc_data_q <= bus.req_op1;
        calc_tag_q  <= free_tag;
      end else if (state_q == ISSUE1) begin
        state_q     <= ISSUE2;
        calc_cmd_q  <= 4'd0;
        calc_data_q <= op2_q;
        calc_tag_q  <= tag_q;
      end else begin
        state_q     <= IDLE;
        calc_cmd_q  <= 4'd0;
        calc_data_q <= 32'd0;
        calc_tag_q  <= 2'd0;
      end

      // Counter starts at 0 in the ISSUE2 cycle and saturates at TIMEOUT.
      for (int i = 0; i < 4; i++) begin
        if ((resp_hit && bus.calc_tag_in == 2'(i)) || (fire_to && pend_tag == 2'(i))) begin
          out_q[i] <= 1'b0;
          cnt_q[i] <= 8'd0;
        end else if (state_q == ISSUE1 && tag_q == 2'(i)) begin
          cnt_q[i] <= 8'd0;
        end else begin
          if (state_q == ISSUE2 && tag_q == 2'(i)) out_q[i] <= 1'b1;
          if ((out_q[i] || (state_q == ISSUE2 && tag_q == 2'(i))) && cnt_q[i] != TO)
            cnt_q[i] <= cnt_q[i] + 8'd1;
        end
      end

      if (resp_hit) begin
        rsp_valid_q  <= 1'b1;
        rsp_status_q <= (bus.calc_resp_in == 2'd1) ? 2'd1 : 2'd2;
        rsp_data_q   <= bus.calc_data_in;
        rsp_tag_q    <= bus.calc_tag_in;
      end else if (fire_to) begin
        rsp_valid_q  <= 1'b1;
        rsp_status_q <= 2'd3;
        rsp_data_q   <= 32'd0;
        rsp_tag_q    <= pend_tag;
      end else begin
        rsp_valid_q  <= 1'b0;
        rsp_status_q <= 2'd0;
        rsp_data_q   <= 32'd0;
        rsp_tag_q    <= 2'd0;
      end

      if (resp_spur) spurious_q <= 1'b1;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.calc_cmd_out  = calc_cmd_q;
  assign bus.calc_data_out = calc_data_q;
  assign bus.calc_tag_out  = calc_tag_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_status    = rsp_status_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_tag       = rsp_tag_q;
  assign busy              = (|out_q) || (state_q != IDLE);
  assign spurious_err      = spurious_q;

endmodule

// File: tb/tb_calc2_port_driver.sv
// Directed bench for calc2_port_driver: vector table of single ops plus multi-cycle corner sequences.
module tb_calc2_port_driver;

  logic c_clk = 1'b0;
  logic reset;
  logic busy;
  logic spurious_err;
  int   checks = 0;
  int   failures = 0;

  calc2_port_driver_if bus_if ();

  calc2_port_driver #(.TIMEOUT(16)) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .bus          (bus_if.master),
    .busy         (busy),
    .spurious_err (spurious_err)
  );

  always #5 c_clk = ~c_clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [1:0]  status;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge c_clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus_if.req_valid    = 1'b0;
    bus_if.req_cmd      = 4'd0;
    bus_if.req_op1      = 32'd0;
    bus_if.req_op2      = 32'd0;
    bus_if.calc_resp_in = 2'd0;
    bus_if.calc_data_in = 32'd0;
    bus_if.calc_tag_in  = 2'd0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic set_req(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2);
    bus_if.req_valid = 1'b1;
    bus_if.req_cmd   = cmd;
    bus_if.req_op1   = op1;
    bus_if.req_op2   = op2;
  endtask

  task automatic set_resp(input logic [1:0] resp, input logic [1:0] tag, input logic [31:0] data);
    bus_if.calc_resp_in = resp;
    bus_if.calc_tag_in  = tag;
    bus_if.calc_data_in = data;
  endtask

  task automatic chk_calc(input string name, input logic [3:0] cmd, input logic [31:0] data,
                          input logic [1:0] tag);
    chk({name, "_cmd"}, 32'(bus_if.calc_cmd_out), 32'(cmd));
    chk({name, "_data"}, bus_if.calc_data_out, data);
    chk({name, "_tag"}, 32'(bus_if.calc_tag_out), 32'(tag));
  endtask

  task automatic chk_rsp(input string name, input logic [1:0] status, input logic [31:0] data,
                         input logic [1:0] tag);
    chk({name, "_valid"}, 32'(bus_if.rsp_valid), 32'd1);
    chk({name, "_status"}, 32'(bus_if.rsp_status), 32'(status));
    chk({name, "_data"}, bus_if.rsp_data, data);
    chk({name, "_tag"}, 32'(bus_if.rsp_tag), 32'(tag));
  endtask

  initial begin
    int lat;
    int cnt;

    vecs[0] = '{cmd: 4'd1, op1: 32'h30,       op2: 32'h20,       resp: 2'd1, rdata: 32'h50,       status: 2'd1};
    vecs[1] = '{cmd: 4'd2, op1: 32'h100,      op2: 32'h1,        resp: 2'd1, rdata: 32'hFF,       status: 2'd1};
    vecs[2] = '{cmd: 4'd5, op1: 32'h1,        op2: 32'h4,        resp: 2'd1, rdata: 32'h10,       status: 2'd1};
    vecs[3] = '{cmd: 4'd6, op1: 32'h80,       op2: 32'h3,        resp: 2'd1, rdata: 32'h10,       status: 2'd1};
    vecs[4] = '{cmd: 4'd9, op1: 32'hDEADBEEF, op2: 32'h12345678, resp: 2'd2, rdata: 32'h0,        status: 2'd2};
    vecs[5] = '{cmd: 4'd2, op1: 32'h5,        op2: 32'h7,        resp: 2'd3, rdata: 32'hFFFFFFFE, status: 2'd2};
    vecs[6] = '{cmd: 4'hF, op1: 32'hFFFFFFFF, op2: 32'h0,        resp: 2'd1, rdata: 32'hFFFFFFFF, status: 2'd1};

    // Reset state, including req_ready low while reset is asserted
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    chk("rst_ready", 32'(bus_if.req_ready), 32'd0);
    chk_calc("rst_calc", 4'd0, 32'd0, 2'd0);
    chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_spur", 32'(spurious_err), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus_if.req_ready), 32'd1);

    // Single ops: two-cycle issue then matched completion
    for (int v = 0; v < 7; v++) begin
      set_req(vecs[v].cmd, vecs[v].op1, vecs[v].op2);
      #1;
      chk("vec_ready", 32'(bus_if.req_ready), 32'd1);
      tick();
      clear_inputs();
      #1;
      chk_calc("vec_issue1", vecs[v].cmd, vecs[v].op1, 2'd0);
      chk("vec_ready_issue1", 32'(bus_if.req_ready), 32'd0);
      tick();
      chk_calc("vec_issue2", 4'd0, vecs[v].op2, 2'd0);
      chk("vec_busy", 32'(busy), 32'd1);
      tick();
      chk_calc("vec_idle", 4'd0, 32'd0, 2'd0);
      set_resp(vecs[v].resp, 2'd0, vecs[v].rdata);
      tick();
      clear_inputs();
      #1;
      chk_rsp("vec_rsp", vecs[v].status, vecs[v].rdata, 2'd0);
      chk("vec_busy_done", 32'(busy), 32'd0);
      tick();
      chk("vec_rsp_pulse", 32'(bus_if.rsp_valid), 32'd0);
    end
    chk("vec_no_spur", 32'(spurious_err), 32'd0);

    // Five back-to-back requests: four tags issued gap-free, fifth waits for a free tag
    do_reset();
    set_req(4'd1, 32'h100, 32'h200);
    #1;
    chk("b2b_ready0", 32'(bus_if.req_ready), 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      set_req(4'd1, 32'h100 + 32'(k), 32'h200 + 32'(k));
      #1;
      chk_calc("b2b_i1", 4'd1, 32'h100 + 32'(k - 1), 2'(k - 1));
      chk("b2b_ready_i1", 32'(bus_if.req_ready), 32'd0);
      tick();
      chk_calc("b2b_i2", 4'd0, 32'h200 + 32'(k - 1), 2'(k - 1));
      chk("b2b_ready_i2", 32'(bus_if.req_ready), 32'd1);
    end
    tick();
    set_req(4'd2, 32'h1004, 32'h2004);
    #1;
    chk_calc("b2b_i1_t3", 4'd1, 32'h103, 2'd3);
    tick();
    chk_calc("b2b_i2_t3", 4'd0, 32'h203, 2'd3);
    chk("b2b_full_i2", 32'(bus_if.req_ready), 32'd0);
    tick();
    chk_calc("b2b_idle", 4'd0, 32'd0, 2'd0);
    chk("b2b_full_idle", 32'(bus_if.req_ready), 32'd0);
    set_resp(2'd1, 2'd2, 32'hAB);
    tick();
    set_resp(2'd0, 2'd0, 32'd0);
    #1;
    chk_rsp("b2b_rsp", 2'd1, 32'hAB, 2'd2);
    chk("b2b_ready_freed", 32'(bus_if.req_ready), 32'd1);
    tick();
    clear_inputs();
    #1;
    chk_calc("b2b_fifth", 4'd2, 32'h1004, 2'd2);

    // Timeout: status 3 exactly 17 cycles after the ISSUE2 cycle
    do_reset();
    set_req(4'd1, 32'h1, 32'h2);
    tick();
    clear_inputs();
    tick();
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      tick();
      if (bus_if.rsp_valid) lat = k;
    end
    chk("to_latency", 32'(lat), 32'd17);
    chk_rsp("to_rsp", 2'd3, 32'd0, 2'd0);
    chk("to_busy", 32'(busy), 32'd0);

    // Spurious response with nothing outstanding
    set_resp(2'd1, 2'd2, 32'h5);
    tick();
    clear_inputs();
    #1;
    chk("spur_set", 32'(spurious_err), 32'd1);
    chk("spur_no_rsp", 32'(bus_if.rsp_valid), 32'd0);
    tick();
    tick();
    tick();
    chk("spur_sticky", 32'(spurious_err), 32'd1);
    chk("spur_no_rsp_later", 32'(bus_if.rsp_valid), 32'd0);
    do_reset();
    chk("spur_cleared", 32'(spurious_err), 32'd0);

    // Timeout of tag0 collides with DUT error for tag1: DUT response wins, timeout deferred
    set_req(4'd1, 32'h10, 32'h11);
    tick();
    set_req(4'd2, 32'h20, 32'h21);
    tick();
    tick();
    clear_inputs();
    repeat (15) tick();
    set_resp(2'd2, 2'd1, 32'h77);
    tick();
    set_resp(2'd0, 2'd0, 32'd0);
    #1;
    chk_rsp("coll_dut", 2'd2, 32'h77, 2'd1);
    tick();
    chk_rsp("coll_to", 2'd3, 32'd0, 2'd0);
    chk("coll_busy", 32'(busy), 32'd0);

    // Reset during ISSUE1 with two tags outstanding drops everything silently
    do_reset();
    set_req(4'd1, 32'h1, 32'h2);
    tick();
    tick();
    set_req(4'd1, 32'h3, 32'h4);
    tick();
    tick();
    set_req(4'd1, 32'h5, 32'h6);
    tick();
    clear_inputs();
    #1;
    chk_calc("mid_issue1", 4'd1, 32'h5, 2'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk_calc("mid_rst_calc", 4'd0, 32'd0, 2'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rsp", 32'(bus_if.rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus_if.req_ready), 32'd1);
    set_req(4'd6, 32'h9, 32'hA);
    tick();
    clear_inputs();
    #1;
    chk_calc("mid_new_tag", 4'd6, 32'h9, 2'd0);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (bus_if.rsp_valid) cnt++;
    end
    chk("mid_no_stale_rsp", 32'(cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
